// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned ADDR_W_DEF   = 8;
    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned LOCK_MAX_DEF = 16;
    localparam int unsigned STAT_W       = 16;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_CORE = 2'd1,
        ARB_HOST = 2'd2,
        ARB_LOCK = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + STAT_W'(1) : v;
    endfunction

endpackage

// File: rtl/dmem_arb_rdreg.sv
// Per-requester load-return register: rvalid one cycle after a load grant,
// rdata captured at the grant edge and held until the next load.
module dmem_arb_rdreg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    // Capture memory read data on a load grant; drop any pending valid on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= load_i;
            if (load_i) begin
                rdata_q <= rdata_i;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing data_mem between the core and the host port,
// with a host burst lock bounded by LOCK_MAX consecutive grants.
// Optional statistics counters: define DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic              CLK,
    input  logic              reset_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       core_wait_cnt,
`endif
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned     CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_MAX);

    arb_state_t       state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    logic core_gnt_c, host_gnt_c;
    logic rr_core_c, rr_host_c;

    // Arbitration state, last owner and lock counter.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_HOST;
            lock_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Grant decision and next state: locked host ownership, else round-robin.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        core_gnt_c = 1'b0;
        host_gnt_c = 1'b0;

        // Round-robin: a lone requester wins; on conflict the non-last owner wins.
        rr_core_c = core_req & (~host_req | (owner_q == OWN_HOST));
        rr_host_c = host_req & ~rr_core_c;

        if ((state_q == ARB_LOCK) && host_lock) begin
            if (core_req && (lock_cnt_q >= LOCK_LIM)) begin
                core_gnt_c = 1'b1;
                state_d    = ARB_CORE;
                owner_d    = OWN_CORE;
                lock_cnt_d = '0;
            end else if (host_req) begin
                host_gnt_c = 1'b1;
                if (lock_cnt_q < LOCK_LIM) begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end
            end
        end else begin
            core_gnt_c = rr_core_c;
            host_gnt_c = rr_host_c;
            if (rr_core_c) begin
                state_d    = ARB_CORE;
                owner_d    = OWN_CORE;
                lock_cnt_d = '0;
            end else if (rr_host_c) begin
                owner_d = OWN_HOST;
                if (host_lock) begin
                    state_d    = ARB_LOCK;
                    lock_cnt_d = CNT_W'(1);
                end else begin
                    state_d    = ARB_HOST;
                    lock_cnt_d = '0;
                end
            end else begin
                state_d    = ARB_IDLE;
                lock_cnt_d = '0;
            end
        end
    end

    // Grants and write enable are gated by reset so an in-flight access aborts at once.
    assign core_gnt   = core_gnt_c & reset_n;
    assign host_gnt   = host_gnt_c & reset_n;
    assign core_stall = core_req & ~core_gnt;
    assign mem_we     = (core_gnt & core_we) | (host_gnt & host_we);
    assign mem_addr   = host_gnt_c ? host_addr  : core_addr;
    assign mem_wdata  = host_gnt_c ? host_wdata : core_wdata;

    dmem_arb_rdreg #(.DATA_W(DATA_W)) u_core_rd (
        .clk_i    (CLK),
        .rst_ni   (reset_n),
        .load_i   (core_gnt & ~core_we),
        .rdata_i  (mem_rdata),
        .rvalid_o (core_rvalid),
        .rdata_o  (core_rdata)
    );

    dmem_arb_rdreg #(.DATA_W(DATA_W)) u_host_rd (
        .clk_i    (CLK),
        .rst_ni   (reset_n),
        .load_i   (host_gnt & ~host_we),
        .rdata_i  (mem_rdata),
        .rvalid_o (host_rvalid),
        .rdata_o  (host_rdata)
    );

`ifdef DMEM_ARB_STATS_EN
    logic [STAT_W-1:0] conflict_q, wait_q;

    // Saturating counts of request conflicts and core stall cycles.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            conflict_q <= '0;
            wait_q     <= '0;
        end else begin
            conflict_q <= sat_inc(conflict_q, core_req & host_req);
            wait_q     <= sat_inc(wait_q, core_stall);
        end
    end

    assign conflict_cnt  = conflict_q;
    assign core_wait_cnt = wait_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (LOCK_MAX = 4) with a
// behavioural data_mem model (combinational read, write on posedge).
module tb_dmem_arbiter;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic       core_req, core_we, core_gnt, core_stall, core_rvalid;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       host_req, host_we, host_lock, host_gnt, host_rvalid;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] conflict_cnt, core_wait_cnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] mem [0:255];

    always #5 CLK = ~CLK;

    assign mem_rdata = mem[mem_addr];
    always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .LOCK_MAX(4)) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_stall  (core_stall),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_lock   (host_lock),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
`ifdef DMEM_ARB_STATS_EN
        .conflict_cnt  (conflict_cnt),
        .core_wait_cnt (core_wait_cnt),
`endif
        .mem_rdata   (mem_rdata)
    );

    task automatic drive(input logic c_req, input logic c_we, input logic [7:0] c_addr,
                         input logic [7:0] c_wd, input logic h_req, input logic h_we,
                         input logic [7:0] h_addr, input logic [7:0] h_wd, input logic h_lock);
        core_req = c_req; core_we = c_we; core_addr = c_addr; core_wdata = c_wd;
        host_req = h_req; host_we = h_we; host_addr = h_addr; host_wdata = h_wd;
        host_lock = h_lock;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    // Inputs change 1 time unit after the rising edge; mid-cycle is 4 units later.
    task automatic next_cycle();
        @(posedge CLK); #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 1'b1, 8'h33, 8'hEE, 1'b1, 1'b1, 8'h44, 8'hDD, 1'b1);
        #3;
        tests_run++;
        if ({core_gnt, host_gnt, mem_we, core_rvalid, host_rvalid} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 00000", {core_gnt, host_gnt, mem_we, core_rvalid, host_rvalid});
        end
        tests_run++;
        if ({core_rdata, host_rdata} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h want 0000", {core_rdata, host_rdata});
        end
        @(posedge CLK); #1;
        idle();
        @(posedge CLK); #1;
        reset_n = 1'b1;
        mid();
        tests_run++;
        if ({core_gnt, host_gnt, mem_we, core_rvalid, host_rvalid} !== 5'b00000) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got %b want 00000", {core_gnt, host_gnt, mem_we, core_rvalid, host_rvalid});
        end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 8'h02, 8'h5A, 1'b0);
        mid();
        tests_run++;
        if ({core_gnt, host_gnt, core_stall, mem_we, mem_addr} !== {4'b1000, 8'h01}) begin
            tests_failed++;
            $display("FAIL sim_first_core: got %b/%h want 1000/01", {core_gnt, host_gnt, core_stall, mem_we}, mem_addr);
        end
        next_cycle();
        drive(1'b0, 1'b0, 8'h01, 8'h00, 1'b1, 1'b1, 8'h02, 8'h5A, 1'b0);
        tests_run++;
        if ({core_rvalid, core_rdata} !== {1'b1, 8'h3C}) begin
            tests_failed++;
            $display("FAIL sim_core_load: got %b/%h want 1/3c", core_rvalid, core_rdata);
        end
        mid();
        tests_run++;
        if ({core_gnt, host_gnt, core_stall, mem_we, mem_addr, mem_wdata} !== {4'b0101, 8'h02, 8'h5A}) begin
            tests_failed++;
            $display("FAIL sim_then_host: got %b/%h/%h want 0101/02/5a", {core_gnt, host_gnt, core_stall, mem_we}, mem_addr, mem_wdata);
        end
        next_cycle();
        idle();
        mid();
        tests_run++;
        if ({core_rvalid, host_rvalid, mem[2]} !== {2'b00, 8'h5A}) begin
            tests_failed++;
            $display("FAIL sim_host_store: got %b/%h want 00/5a", {core_rvalid, host_rvalid}, mem[2]);
        end
        next_cycle();
    endtask

    task automatic test_core_only();
        drive(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        mid();
        tests_run++;
        if ({core_gnt, core_stall, mem_we, mem_addr, mem_wdata} !== {3'b101, 8'h10, 8'hA5}) begin
            tests_failed++;
            $display("FAIL core_store: got %b/%h/%h want 101/10/a5", {core_gnt, core_stall, mem_we}, mem_addr, mem_wdata);
        end
        next_cycle();
        drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        mid();
        tests_run++;
        if ({core_gnt, core_stall, mem_we, core_rvalid} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL core_load_gnt: got %b want 1000", {core_gnt, core_stall, mem_we, core_rvalid});
        end
        next_cycle();
        idle();
        tests_run++;
        if ({core_rvalid, core_rdata} !== {1'b1, 8'hA5}) begin
            tests_failed++;
            $display("FAIL core_load_data: got %b/%h want 1/a5", core_rvalid, core_rdata);
        end
        next_cycle();
        tests_run++;
        if ({core_rvalid, core_rdata} !== {1'b0, 8'hA5}) begin
            tests_failed++;
            $display("FAIL core_rdata_hold: got %b/%h want 0/a5", core_rvalid, core_rdata);
        end
    endtask

    task automatic test_alternate();
        logic exp_c;
        drive(1'b0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 8'h30, 8'h77, 1'b0);
        mid();
        tests_run++;
        if ({core_gnt, host_gnt} !== 2'b01) begin
            tests_failed++;
            $display("FAIL alt_host_only: got %b want 01", {core_gnt, host_gnt});
        end
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b0, 8'h30, 8'h00, 1'b0);
            mid();
            exp_c = ((i % 2) == 0);
            tests_run++;
            if ({core_gnt, host_gnt, core_stall, mem_addr} !== {exp_c, ~exp_c, ~exp_c, (exp_c ? 8'h20 : 8'h30)}) begin
                tests_failed++;
                $display("FAIL alt_cycle%0d: got %b/%h want %b", i, {core_gnt, host_gnt, core_stall}, mem_addr, {exp_c, ~exp_c, ~exp_c});
            end
        end
        next_cycle();
        idle();
    endtask

    task automatic test_lock_burst();
        logic [5:0] exp_core;
        logic [5:0] exp_host;
        exp_core = 6'b010000;
        exp_host = 6'b101111;
        drive(1'b1, 1'b1, 8'h40, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        mid();
        tests_run++;
        if (core_gnt !== 1'b1) begin
            tests_failed++;
            $display("FAIL lock_setup: got %b want 1", core_gnt);
        end
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            drive(1'b1, 1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 8'h50, 8'h60 + 8'(i), 1'b1);
            if (i == 5) begin
                tests_run++;
                if ({core_rvalid, core_rdata} !== {1'b1, 8'h11}) begin
                    tests_failed++;
                    $display("FAIL lock_forced_load: got %b/%h want 1/11", core_rvalid, core_rdata);
                end
            end
            mid();
            tests_run++;
            if ({core_gnt, host_gnt, core_stall} !== {exp_core[i], exp_host[i], ~exp_core[i]}) begin
                tests_failed++;
                $display("FAIL lock_cycle%0d: got %b want %b", i + 1, {core_gnt, host_gnt, core_stall}, {exp_core[i], exp_host[i], ~exp_core[i]});
            end
        end
        // Locked host load, then a locked store that the reset will abort.
        next_cycle();
        drive(1'b0, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00, 1'b1);
        mid();
        tests_run++;
        if ({host_gnt, mem_we, mem_addr} !== {2'b10, 8'h50}) begin
            tests_failed++;
            $display("FAIL lock_host_load: got %b/%h want 10/50", {host_gnt, mem_we}, mem_addr);
        end
        next_cycle();
        drive(1'b0, 1'b0, 8'h40, 8'h00, 1'b1, 1'b1, 8'h51, 8'h99, 1'b1);
        tests_run++;
        if ({host_rvalid, host_rdata} !== {1'b1, 8'h65}) begin
            tests_failed++;
            $display("FAIL lock_host_rdata: got %b/%h want 1/65", host_rvalid, host_rdata);
        end
    endtask

    task automatic test_async_reset();
        mid();
        tests_run++;
        if ({host_gnt, mem_we, host_rvalid} !== 3'b111) begin
            tests_failed++;
            $display("FAIL areset_pre: got %b want 111", {host_gnt, mem_we, host_rvalid});
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({core_gnt, host_gnt, mem_we, core_rvalid, host_rvalid, host_rdata} !== {5'b00000, 8'h00}) begin
            tests_failed++;
            $display("FAIL areset_immediate: got %b/%h want 00000/00", {core_gnt, host_gnt, mem_we, core_rvalid, host_rvalid}, host_rdata);
        end
        next_cycle();
        tests_run++;
        if (mem[8'h51] !== 8'h00) begin
            tests_failed++;
            $display("FAIL areset_store_aborted: got %h want 00", mem[8'h51]);
        end
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
        mid();
        tests_run++;
        if ({core_gnt, host_gnt} !== 2'b10) begin
            tests_failed++;
            $display("FAIL areset_conflict: got %b want 10", {core_gnt, host_gnt});
        end
        next_cycle();
        idle();
        tests_run++;
        if ({core_rvalid, core_rdata} !== {1'b1, 8'h3C}) begin
            tests_failed++;
            $display("FAIL areset_core_load: got %b/%h want 1/3c", core_rvalid, core_rdata);
        end
        next_cycle();
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        reset_n = 1'b0;
        idle();
        next_cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
            next_cycle();
        end
        idle();
        tests_run++;
        if ({conflict_cnt, core_wait_cnt} !== {16'd10, 16'd5}) begin
            tests_failed++;
            $display("FAIL stats_count: got %0d/%0d want 10/5", conflict_cnt, core_wait_cnt);
        end
        drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            next_cycle();
        end
        idle();
        tests_run++;
        if (conflict_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL stats_saturate: got %h want ffff", conflict_cnt);
        end
        next_cycle();
    endtask
`endif

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[1] = 8'h3C;
        reset_n = 1'b0;
        idle();
        #2;
        test_reset();
        test_simultaneous();
        test_core_only();
        test_alternate();
        test_lock_burst();
        test_async_reset();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data_mem between two requesters: the processor core (load/store path) and a host port (program/data loader, result dump).
- Sits between the core's memory controls and data_mem; the core stalls via core_stall while the host owns the memory.
- Round-robin arbitration with a host burst lock, bounded by a lock timeout so the core cannot starve.

Parameters:
- ADDR_W, 8, data memory address width
- DATA_W, 8, data word width
- LOCK_MAX, 16, max consecutive locked host grants before a forced one-cycle core slot (>=1)

Ports:
- CLK  in  1  clock, posedge
- reset_n  in  1  asynchronous active-low reset
- core_req  in  1  core requests an access this cycle
- core_we  in  1  1 = store, 0 = load
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core store data
- core_gnt  out  1  core access performed this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rvalid  out  1  load data valid (cycle after grant of a load)
- core_rdata  out  DATA_W  registered load data
- host_req, host_we, host_addr, host_wdata  in  1/1/ADDR_W/DATA_W  host request, same meaning as core
- host_lock  in  1  host holds ownership across consecutive grants
- host_gnt, host_rvalid, host_rdata  out  1/1/DATA_W  host equivalents of core outputs
- mem_addr  out  ADDR_W  to data_mem DataAddress
- mem_we  out  1  to data_mem WriteMem
- mem_wdata  out  DATA_W  to data_mem DataIn
- mem_rdata  in  DATA_W  from data_mem DataOut (combinational read)

Behaviour:
- Reset (reset_n low, async): state ARB_IDLE, last_owner = HOST, lock_cnt = 0; all gnt, rvalid, mem_we = 0; rdata regs = 0; a pending rvalid is dropped.
- Grants are combinational from current requests and registered state; the access happens in the grant cycle. Only one of core_gnt/host_gnt may be high, and a gnt is never high without its req.
- mem_addr/mem_wdata mux from the granted requester; mem_we = gnt & we. With no grant, mem_we = 0 and mem_addr holds the core address.
- Load latency: rvalid is high exactly 1 cycle after a load grant, with rdata = mem_rdata sampled at the grant edge. rdata holds its value until the next load. Stores produce no rvalid.
- FSM states: ARB_IDLE, ARB_CORE, ARB_HOST, ARB_LOCK. The state records the last owner and the lock.
  - IDLE/CORE/HOST:
    - One requester active: it is granted.
    - Both active: grant the requester that is not last_owner.
    - Next state = owner of the grant, else ARB_IDLE (last_owner retained).
  - Host granted with host_lock = 1: go to ARB_LOCK, lock_cnt = 1.
  - ARB_LOCK:
    - Core never granted; host granted whenever host_req is high, and lock_cnt increments per host grant.
    - host_lock low: normal round-robin that cycle; last_owner = HOST, so the core wins a conflict.
    - lock_cnt == LOCK_MAX and core_req high: force one core grant and go to ARB_CORE, lock_cnt = 0. The host may re-lock on its next grant.
    - host_req low while host_lock high: stay in ARB_LOCK, no grant; lock_cnt is not incremented.
- Back-to-back grants to the same requester are allowed every cycle.
- Reset asserted mid-access: the access in that cycle is aborted (mem_we forced 0 asynchronously).

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined:
  - Adds output conflict_cnt [15:0], which counts cycles where both reqs are high, and output core_wait_cnt [15:0], which counts cycles with core_stall high.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_CORE, ARB_HOST, ARB_LOCK}
  - typedef enum logic owner_t {OWN_CORE, OWN_HOST}
  - default width constants
- One sub-module: dmem_arb_rdreg, the per-requester load-return register (rvalid/rdata capture). It is instantiated twice.

Test Plan:
- Core only: store addr 8'h10 data 8'hA5, then load 8'h10 → core_gnt both cycles, core_rvalid 1 cycle after the load with core_rdata = 8'hA5, core_stall never high.
- Simultaneous first requests after reset: both req, core load 8'h01 and host store 8'h02 → core granted first (last_owner = HOST reset value), host granted next cycle, core_stall 0, host stalled 1 cycle.
- Continuous both-req for 6 cycles, no lock → strictly alternating grants C,H,C,H,C,H.
- Host burst with host_lock = 1 and core_req = 1, LOCK_MAX = 4 → host granted 4 cycles, core granted cycle 5, host regains lock from cycle 6; core_stall high for cycles 1–4.
- Async reset asserted mid-burst in ARB_LOCK with a load just granted → all gnt, mem_we, rvalid = 0 immediately. After release, state ARB_IDLE and the next conflict goes to the core.
- DMEM_ARB_STATS_EN defined, 10 conflict cycles → conflict_cnt = 10; forced counter preset near 16'hFFFF → saturates, no wrap.
